dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts one load/store,
// freezes the pipeline via stall_o for LATENCY cycles, then pulses ack_o.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRd_i,
    input  logic        MemWr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        stall_o,
    output logic        err_o,
    output logic [1:0]  state_o
);

    // Handshake: a request (MemRd_i | MemWr_i) is accepted in IDLE at the edge
    // ending the cycle it is seen; stall_o stays high until the RESP cycle, where
    // ack_o pulses once and request lines still present are treated as the same
    // instruction and ignored.

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          rd_q, wr_q, err_q;
    logic [31:0]   data_q;
    logic          ack_q, err_o_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          req_err;
    logic          rd_cur, err_cur;
    logic [AW-1:0] idx_cur;

    assign req     = MemRd_i | MemWr_i;
    assign req_err = (addr_i[1:0] != 2'b00)
                   || ({2'b00, addr_i[31:2]} >= 32'(DEPTH_WORDS))
                   || (MemRd_i & MemWr_i);

    // With LATENCY=1 RESP is entered straight from IDLE, before anything is latched.
    assign rd_cur  = (state_q == S_IDLE) ? MemRd_i : rd_q;
    assign err_cur = (state_q == S_IDLE) ? req_err : err_q;
    assign idx_cur = (state_q == S_IDLE) ? addr_i[AW+1:2] : idx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_o_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req) begin
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= data_i;
                rd_q    <= MemRd_i;
                wr_q    <= MemWr_i;
                err_q   <= req_err;
            end
            ack_q   <= (state_d == S_RESP);
            err_o_q <= (state_d == S_RESP) && err_cur;
            if (state_d == S_RESP && rd_cur) begin
                data_q <= err_cur ? 32'd0 : mem[idx_cur];
            end
        end
    end

    // The store commits on the edge leaving RESP; reset in that cycle cancels it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == S_RESP && wr_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign data_o  = data_q;
    assign ack_o   = ack_q;
    assign err_o   = err_o_q;
    assign state_o = state_q;
    assign stall_o = !rst_i && ((state_q == S_BUSY) || (state_q == S_IDLE && req));

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-level memory model,
// plus directed reset/error/abort cases and a LATENCY=1 instance.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rd, wr;
    logic [31:0] addr, wdata;
    logic [31:0] dout;
    logic        ack, stall, err;
    logic [1:0]  state;

    logic        rst1, rd1, wr1;
    logic [31:0] addr1, wdata1;
    logic [31:0] dout1;
    logic        ack1, stall1, err1;
    logic [1:0]  state1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rst_i(rst), .MemRd_i(rd), .MemWr_i(wr), .addr_i(addr),
        .data_i(wdata), .data_o(dout), .ack_o(ack), .stall_o(stall),
        .err_o(err), .state_o(state)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .MemRd_i(rd1), .MemWr_i(wr1), .addr_i(addr1),
        .data_i(wdata1), .data_o(dout1), .ack_o(ack1), .stall_o(stall1),
        .err_o(err1), .state_o(state1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] exp_dout;
    int          last_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_err(input logic r, input logic w, input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH) || (r && w);
    endfunction

    // One transaction on the LATENCY=3 instance; the request is held through RESP
    // (with scrambled address/data) unless drop models a flush after acceptance.
    task automatic txn(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit drop);
        logic        e;
        logic [31:0] ed;
        logic [32:0] x;
        rd = r; wr = w; addr = a; wdata = d;
        e  = is_err(r, w, a);
        if (r) ed = e ? 32'd0 : model_mem[int'(a >> 2)];
        else   ed = exp_dout;
        exp_q.push_back({e, ed});
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check(k < LAT ? "stall_phase" : "resp_phase", {stall, ack},
                  k < LAT ? 2'b10 : 2'b01);
            if (k == LAT) begin
                x = exp_q.pop_front();
                check("err_data", {err, dout}, x);
                exp_dout = x[31:0];
                if (w && !e) model_mem[int'(a >> 2)] = d;
                last_ack = cyc;
            end
            @(posedge clk);
            #1;
            if (k < LAT) begin
                addr  = $urandom;
                wdata = $urandom;
                if (drop) begin
                    rd = 1'b0;
                    wr = 1'b0;
                end
            end
        end
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle", {stall, ack}, 2'b00);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic txn1(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [32:0] exp_ed);
        rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
        @(negedge clk);
        check("l1_stall", {stall1, ack1}, 2'b10);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("l1_resp", {stall1, ack1}, 2'b01);
        check("l1_err_data", {err1, dout1}, exp_ed);
        @(posedge clk);
        #1;
        rd1 = 1'b0;
        wr1 = 1'b0;
    endtask

    initial begin
        int first_ack;
        int sel;
        logic r, w;
        logic [31:0] a;

        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h13; wdata = '0;
        rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        exp_dout = '0;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs", {stall, ack, dout}, '0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;

        // Held request is accepted right after release: misaligned load errors.
        txn(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);

        txn(1'b0, 1'b1, 32'h00, 32'h1111_0000, 1'b0);
        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        txn(1'b0, 1'b1, 32'(4 * DEPTH), 32'h0BAD_0BAD, 1'b0);
        txn(1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
        txn(1'b1, 1'b1, 32'h10, 32'h5555_5555, 1'b0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Back-to-back: second ack exactly LAT+1 cycles after the first.
        txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        first_ack = last_ack;
        txn(1'b0, 1'b1, 32'h24, 32'h2424_2424, 1'b0);
        check("b2b_spacing", 64'(last_ack - first_ack), 64'(LAT + 1));
        txn(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);

        txn(1'b0, 1'b1, 32'h28, 32'h2828_0001, 1'b1);
        txn(1'b1, 1'b0, 32'h28, 32'h0, 1'b1);

        // Abort: reset in the second BUSY cycle of a store.
        txn(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b0);
        txn(1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        rd = 1'b0; wr = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        wr  = 1'b0;
        @(negedge clk);
        check("abort_stall_low", {stall, ack}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_dout = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_ack", {stall, ack, dout}, '0);
            @(posedge clk); #1;
        end
        txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            r = $urandom_range(0, 1);
            w = !r;
            a = 32'($urandom_range(0, 15)) << 2;
            if (sel == 0) begin
                a = a + 32'($urandom_range(1, 3));
            end else if (sel == 1) begin
                a = 32'($urandom_range(DEPTH, 1 << 20)) << 2;
            end else if (sel == 2) begin
                r = 1'b1;
                w = 1'b1;
            end else if (r && !model_mem.exists(int'(a >> 2))) begin
                r = 1'b0;
                w = 1'b1;
            end
            txn(r, w, a, $urandom, ($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        rst1 = 1'b0;
        txn1(1'b0, 1'b1, 32'h0C, 32'hCAFE_0001, {1'b0, 32'h0});
        txn1(1'b1, 1'b0, 32'h0C, 32'h0, {1'b0, 32'hCAFE_0001});
        txn1(1'b1, 1'b0, 32'h0E, 32'h0, {1'b1, 32'h0});
        @(negedge clk);
        check("l1_idle", {stall1, ack1}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
